// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : fetch-stage instruction pointer with stall, branch redirect,
//                trap entry/return, target alignment check and double-fault halt
// Revision     : 1.0
// ============================================================================
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 32
) (
  input  logic            i_Clock,
  input  logic            i_Reset_n,
  input  logic            i_Stall,
  input  logic            i_BranchTaken,
  input  logic [XLEN-1:0] i_BranchTarget,
  input  logic            i_Trap,
  input  logic [3:0]      i_TrapCause,
  input  logic            i_TrapReturn,
  input  logic [XLEN-1:0] i_TrapVector,
  output logic [XLEN-1:0] o_InstructionPointer,
  output logic            o_Valid,
  output logic [XLEN-1:0] o_Epc,
  output logic [3:0]      o_Cause,
  output logic [XLEN-1:0] o_BadAddr,
  output logic            o_InHandler,
  output logic            o_Halted
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RUN     = 2'd1,
    S_HANDLER = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] C_INCR = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] ip_q, ip_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic [3:0]      cause_q, cause_d;

  logic            w_misaligned;
  logic            w_fault;
  logic [XLEN-1:0] w_trap_base;
  logic            w_unused_vector_lsbs;

  generate
    if (IALIGN == 16) begin : g_ialign16
      assign w_misaligned = i_BranchTaken & i_BranchTarget[0];
    end else begin : g_ialign32
      assign w_misaligned = i_BranchTaken & (|i_BranchTarget[1:0]);
    end
  endgenerate

  // Direct-mode vector: the low two bits of the handler base are mode bits.
  assign w_trap_base          = {i_TrapVector[XLEN-1:2], 2'b00};
  assign w_unused_vector_lsbs = ^i_TrapVector[1:0];
  assign w_fault              = i_Trap | w_misaligned;

  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    bad_addr_d = bad_addr_q;

    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_HANDLER: begin
        if (w_fault) begin
          if (state_q == S_RUN) begin
            epc_d      = ip_q;
            cause_d    = w_misaligned ? 4'd0 : i_TrapCause;
            bad_addr_d = w_misaligned ? i_BranchTarget : '0;
            ip_d       = w_trap_base;
            state_d    = S_HANDLER;
          end else begin
            state_d    = S_HALT;
          end
        end else if (i_TrapReturn && (state_q == S_HANDLER)) begin
          ip_d    = epc_q;
          state_d = S_RUN;
        end else if (i_BranchTaken) begin
          ip_d = i_BranchTarget;
        end else if (!i_Stall) begin
          ip_d = ip_q + C_INCR;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= S_BOOT;
      ip_q       <= RESET_VECTOR;
      epc_q      <= '0;
      cause_q    <= '0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign o_InstructionPointer = ip_q;
  assign o_Epc                = epc_q;
  assign o_Cause              = cause_q;
  assign o_BadAddr            = bad_addr_q;
  assign o_Valid              = (state_q == S_RUN) || (state_q == S_HANDLER);
  assign o_InHandler          = (state_q == S_HANDLER);
  assign o_Halted             = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed and random checks of two sequencers (IALIGN 32/16)
// Revision        : 1.0
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] C_RV = 32'h100;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n;
  logic        i_Stall, i_BranchTaken, i_Trap, i_TrapReturn;
  logic [31:0] i_BranchTarget, i_TrapVector;
  logic [3:0]  i_TrapCause;

  logic [31:0] ip32, epc32, bad32, ip16, epc16, bad16;
  logic [3:0]  cause32, cause16;
  logic        val32, inh32, hlt32, val16, inh16, hlt16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_Clock = ~i_Clock;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(C_RV), .IALIGN(32)) u_dut32 (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Stall(i_Stall),
    .i_BranchTaken(i_BranchTaken), .i_BranchTarget(i_BranchTarget),
    .i_Trap(i_Trap), .i_TrapCause(i_TrapCause), .i_TrapReturn(i_TrapReturn),
    .i_TrapVector(i_TrapVector), .o_InstructionPointer(ip32), .o_Valid(val32),
    .o_Epc(epc32), .o_Cause(cause32), .o_BadAddr(bad32),
    .o_InHandler(inh32), .o_Halted(hlt32));

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(C_RV), .IALIGN(16)) u_dut16 (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Stall(i_Stall),
    .i_BranchTaken(i_BranchTaken), .i_BranchTarget(i_BranchTarget),
    .i_Trap(i_Trap), .i_TrapCause(i_TrapCause), .i_TrapReturn(i_TrapReturn),
    .i_TrapVector(i_TrapVector), .o_InstructionPointer(ip16), .o_Valid(val16),
    .o_Epc(epc16), .o_Cause(cause16), .o_BadAddr(bad16),
    .o_InHandler(inh16), .o_Halted(hlt16));

  // Reference model: architectural view of the sequencer as a few flags.
  typedef struct {
    logic [31:0] ip, epc, bad;
    logic [3:0]  cause;
    bit          booted, in_handler, halted;
  } model_t;

  model_t m32, m16;

  function automatic model_t model_reset();
    model_t r;
    r.ip = C_RV; r.epc = 0; r.bad = 0; r.cause = 0;
    r.booted = 0; r.in_handler = 0; r.halted = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t s, int ialign);
    model_t n = s;
    bit     mis;
    if (s.halted) return n;
    if (!s.booted) begin
      n.booted = 1;
      return n;
    end
    mis = i_BranchTaken && ((ialign == 32) ? (i_BranchTarget % 4 != 0)
                                            : (i_BranchTarget % 2 != 0));
    if (i_Trap || mis) begin
      if (s.in_handler) begin
        n.halted     = 1;
        n.in_handler = 0;
      end else begin
        n.epc        = s.ip;
        n.cause      = mis ? 4'd0 : i_TrapCause;
        n.bad        = mis ? i_BranchTarget : 32'd0;
        n.ip         = i_TrapVector - (i_TrapVector % 4);
        n.in_handler = 1;
      end
    end else if (i_TrapReturn && s.in_handler) begin
      n.ip         = s.epc;
      n.in_handler = 0;
    end else if (i_BranchTaken) begin
      n.ip = i_BranchTarget;
    end else if (!i_Stall) begin
      n.ip = s.ip + 32'd4;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ip32",    ip32,    m32.ip);
    check("valid32", {31'd0, val32}, {31'd0, m32.booted && !m32.halted});
    check("epc32",   epc32,   m32.epc);
    check("cause32", {28'd0, cause32}, {28'd0, m32.cause});
    check("bad32",   bad32,   m32.bad);
    check("inh32",   {31'd0, inh32}, {31'd0, m32.in_handler});
    check("hlt32",   {31'd0, hlt32}, {31'd0, m32.halted});
    check("ip16",    ip16,    m16.ip);
    check("valid16", {31'd0, val16}, {31'd0, m16.booted && !m16.halted});
    check("epc16",   epc16,   m16.epc);
    check("cause16", {28'd0, cause16}, {28'd0, m16.cause});
    check("bad16",   bad16,   m16.bad);
    check("inh16",   {31'd0, inh16}, {31'd0, m16.in_handler});
    check("hlt16",   {31'd0, hlt16}, {31'd0, m16.halted});
  endtask

  task automatic idle_inputs();
    i_Stall = 0; i_BranchTaken = 0; i_BranchTarget = 0; i_Trap = 0;
    i_TrapCause = 0; i_TrapReturn = 0;
  endtask

  task automatic cycle();
    @(posedge i_Clock);
    m32 = model_step(m32, 32);
    m16 = model_step(m16, 16);
    #1;
    check_all();
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    #2;
    i_Reset_n = 1'b0;
    #1;
    m32 = model_reset();
    m16 = model_reset();
    check_all();
    idle_inputs();
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    i_Reset_n = 1'b0;
    i_TrapVector = 32'h300;
    idle_inputs();
    m32 = model_reset();
    m16 = model_reset();
    #12;
    check_all();
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    #1;
    check("t1_boot_ip", ip32, 32'h100);
    check("t1_boot_valid", {31'd0, val32}, 32'd0);

    // Boot, then sequential advance.
    cycle(); check("t1_ip0", ip32, 32'h100);
    cycle(); check("t1_ip1", ip32, 32'h104);
    cycle(); check("t1_ip2", ip32, 32'h108);

    // Stall holds; branch acts through stall.
    i_Stall = 1;
    repeat (3) cycle();
    check("t2_stall_ip", ip32, 32'h108);
    i_BranchTaken = 1; i_BranchTarget = 32'h200;
    cycle(); check("t2_branch_ip", ip32, 32'h200);
    idle_inputs();

    // Misaligned branch: traps with IALIGN=32, plain branch with IALIGN=16.
    i_BranchTaken = 1; i_BranchTarget = 32'h10;
    cycle();
    i_BranchTarget = 32'h202;
    cycle();
    check("t3_ip32",  ip32,  32'h300);
    check("t3_epc32", epc32, 32'h10);
    check("t3_bad32", bad32, 32'h202);
    check("t3_ip16",  ip16,  32'h202);
    idle_inputs();
    i_TrapReturn = 1;
    cycle();
    check("t3_ret_ip32", ip32, 32'h10);
    idle_inputs();

    // Trap with a vector whose low bits must be dropped, then mret.
    i_BranchTaken = 1; i_BranchTarget = 32'h40;
    cycle();
    idle_inputs();
    i_Trap = 1; i_TrapCause = 4'd11; i_TrapVector = 32'h83;
    i_BranchTaken = 1; i_BranchTarget = 32'h44;
    cycle();
    check("t4_ip",    ip32,  32'h80);
    check("t4_epc",   epc32, 32'h40);
    check("t4_cause", {28'd0, cause32}, 32'd11);
    idle_inputs();
    i_TrapReturn = 1;
    cycle();
    check("t4_ret_ip", ip32, 32'h40);
    idle_inputs();

    // Double fault halts; inputs ignored until reset.
    i_Trap = 1; i_TrapCause = 4'd2;
    cycle();
    i_TrapCause = 4'd5;
    cycle();
    check("t5_halted", {31'd0, hlt32}, 32'd1);
    check("t5_ip", ip32, 32'h80);
    i_Trap = 0; i_TrapReturn = 1; i_BranchTaken = 1; i_BranchTarget = 32'h500;
    repeat (2) cycle();
    async_reset();
    cycle();

    // PC wraps at the top of the address space.
    i_BranchTaken = 1; i_BranchTarget = 32'hFFFF_FFFC;
    cycle();
    idle_inputs();
    cycle();
    check("t6_wrap", ip32, 32'h0);
    cycle();
    async_reset();

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      i_Stall       = ($urandom % 4) == 0;
      i_BranchTaken = ($urandom % 4) == 0;
      i_BranchTarget = $urandom;
      if (($urandom % 3) != 0) i_BranchTarget[1:0] = 2'b00;
      i_Trap        = ($urandom % 16) == 0;
      i_TrapCause   = 4'($urandom);
      i_TrapReturn  = ($urandom % 5) == 0;
      i_TrapVector  = $urandom;
      cycle();
      if ((m32.halted && m16.halted) || ($urandom % 200) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
